// File: rtl/rvj1_defines.sv
// Shared constants and types for the rvj1 core.
// Register address width, LSU depth default and the issue-hazard FSM states.
package rvj1_defines;

  localparam int RALEN         = 5;
  localparam int NREGS         = 2 ** RALEN;
  localparam int LSU_MAX_OUTST = 2;

  typedef enum logic {
    HZD_RUN   = 1'b0,
    HZD_DRAIN = 1'b1
  } hzd_state_e;

endpackage

// File: rtl/rvj1_hzd_sb.sv
// Pending-load scoreboard: one bit per architectural register.
// Set and clear apply in the same edge; on a same-register collision the set wins.
module rvj1_hzd_sb
  import rvj1_defines::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [RALEN-1:0] set_rd,
  input  logic             clr_en,
  input  logic [RALEN-1:0] clr_rd,
  input  logic [RALEN-1:0] rd_a,
  input  logic [RALEN-1:0] rd_b,
  input  logic [RALEN-1:0] rd_c,
  output logic [NREGS-1:0] sb,
  output logic             hit_a,
  output logic             hit_b,
  output logic             hit_c,
  output logic             collide
);

  logic [NREGS-1:0] sb_q;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] sb_next;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_rd] = 1'b1;
    if (clr_en) clr_mask[clr_rd] = 1'b1;
    sb_next    = (sb_q & ~clr_mask) | set_mask;
    // x0 is hardwired zero, so a load to it never blocks anyone
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_next;
  end

  assign sb      = sb_q;
  assign hit_a   = sb_q[rd_a];
  assign hit_b   = sb_q[rd_b];
  assign hit_c   = sb_q[rd_c];
  assign collide = set_en & clr_en & (set_rd == clr_rd);

endmodule

// File: rtl/rvj1_hzd.sv
// Issue-hazard controller: drives the decoder stall from the load scoreboard,
// the outstanding-LSU counter and a RUN/DRAIN fence FSM.
module rvj1_hzd
  import rvj1_defines::*;
#(
  parameter  int MAX_OUTST = LSU_MAX_OUTST,
  localparam int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ifu_valid_i,
  input  logic [RALEN-1:0] dec_rs1_i,
  input  logic [RALEN-1:0] dec_rs2_i,
  input  logic             dec_rs1_use_i,
  input  logic             dec_rs2_use_i,
  input  logic [RALEN-1:0] dec_rd_i,
  input  logic             dec_is_load_i,
  input  logic             dec_is_store_i,
  input  logic             dec_drain_i,
  input  logic             lsu_done_i,
  input  logic             lsu_done_load_i,
  input  logic [RALEN-1:0] lsu_done_rd_i,
  output logic             stall_o,
  output logic [NREGS-1:0] sb_o,
  output logic [CNT_W-1:0] outst_o,
  output logic             drain_o,
  output logic             err_o
);

  // Handshake: the decoder fires (issue) in any cycle with ifu_valid_i high
  // and stall_o low; stall_o depends only on registered state and the
  // current decoder inputs, never on the same-cycle lsu_done_i.

  hzd_state_e state_q, state_d;
  logic [CNT_W-1:0] outst_q;
  logic             err_q;

  logic hit_rs1, hit_rs2, hit_rd;
  logic collide;
  logic is_mem;
  logic outst_zero, outst_full;
  logic raw, waw, full;
  logic issue;
  logic inc, dec, underflow;
  logic sb_set, sb_clr;

  assign is_mem     = dec_is_load_i | dec_is_store_i;
  assign outst_zero = (outst_q == '0);
  assign outst_full = (outst_q == CNT_W'(MAX_OUTST));

  assign raw  = (dec_rs1_use_i & hit_rs1) | (dec_rs2_use_i & hit_rs2);
  assign waw  = dec_is_load_i & hit_rd;
  assign full = is_mem & outst_full;

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    case (state_q)
      HZD_RUN: begin
        stall_o = ifu_valid_i & (raw | waw | full | (dec_drain_i & ~outst_zero));
        if (ifu_valid_i & dec_drain_i & ~outst_zero) state_d = HZD_DRAIN;
      end
      HZD_DRAIN: begin
        // Hold through the cycle that first sees an empty LSU; the fence
        // issues from RUN on the following cycle.
        stall_o = 1'b1;
        if (outst_zero) state_d = HZD_RUN;
      end
      default: begin
        stall_o = 1'b1;
        state_d = HZD_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= HZD_RUN;
    else       state_q <= state_d;
  end

  assign issue     = ifu_valid_i & ~stall_o;
  assign inc       = issue & is_mem;
  assign dec       = lsu_done_i;
  assign underflow = dec & outst_zero;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outst_q <= '0;
    end else begin
      case ({inc, dec})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   if (!outst_zero) outst_q <= outst_q - 1'b1;
        default: outst_q <= outst_q;
      endcase
    end
  end

  assign sb_set = issue & dec_is_load_i & (dec_rd_i != '0);
  assign sb_clr = lsu_done_i & lsu_done_load_i;

  rvj1_hzd_sb u_sb (
    .clk     (clk_i),
    .rst     (rst_i),
    .set_en  (sb_set),
    .set_rd  (dec_rd_i),
    .clr_en  (sb_clr),
    .clr_rd  (lsu_done_rd_i),
    .rd_a    (dec_rs1_i),
    .rd_b    (dec_rs2_i),
    .rd_c    (dec_rd_i),
    .sb      (sb_o),
    .hit_a   (hit_rs1),
    .hit_b   (hit_rs2),
    .hit_c   (hit_rd),
    .collide (collide)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_q | underflow | collide;
  end

  assign outst_o = outst_q;
  assign drain_o = (state_q == HZD_DRAIN);
  assign err_o   = err_q;

endmodule

// File: tb/tb_rvj1_hzd.sv
// Self-checking bench for rvj1_hzd: directed scenarios plus random traffic,
// all compared cycle by cycle against an abstract register/count model.
module tb_rvj1_hzd;

  localparam int MAX = 2;
  localparam int CW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid = 1'b0;
  logic [4:0]    rs1 = '0, rs2 = '0, rd = '0, done_rd = '0;
  logic          rs1_use = 1'b0, rs2_use = 1'b0;
  logic          is_load = 1'b0, is_store = 1'b0, drain = 1'b0;
  logic          done = 1'b0, done_load = 1'b0;
  logic          stall_o;
  logic [31:0]   sb_o;
  logic [CW-1:0] outst_o;
  logic          drain_o, err_o;

  rvj1_hzd #(.MAX_OUTST(MAX)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ifu_valid_i     (valid),
    .dec_rs1_i       (rs1),
    .dec_rs2_i       (rs2),
    .dec_rs1_use_i   (rs1_use),
    .dec_rs2_use_i   (rs2_use),
    .dec_rd_i        (rd),
    .dec_is_load_i   (is_load),
    .dec_is_store_i  (is_store),
    .dec_drain_i     (drain),
    .lsu_done_i      (done),
    .lsu_done_load_i (done_load),
    .lsu_done_rd_i   (done_rd),
    .stall_o         (stall_o),
    .sb_o            (sb_o),
    .outst_o         (outst_o),
    .drain_o         (drain_o),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Abstract model: set of pending load destinations, count of LSU ops in
  // flight, whether a fence is waiting, sticky error; exp_q holds the
  // in-flight ops ({is_load, rd}) in issue order.
  logic [31:0] m_sb;
  int          m_cnt;
  bit          m_drain;
  bit          m_err;
  logic [5:0]  exp_q[$];
  logic        last_stall;

  task automatic model_reset();
    m_sb = '0; m_cnt = 0; m_drain = 0; m_err = 0; exp_q.delete();
  endtask

  task automatic idle();
    valid = 0; rs1 = '0; rs2 = '0; rs1_use = 0; rs2_use = 0; rd = '0;
    is_load = 0; is_store = 0; drain = 0; done = 0; done_load = 0; done_rd = '0;
  endtask

  task automatic instr(input bit ld, input bit st, input bit dr, input logic [4:0] d,
                       input logic [4:0] a, input bit ua, input logic [4:0] b, input bit ub);
    valid = 1; is_load = ld; is_store = st; drain = dr; rd = d;
    rs1 = a; rs1_use = ua; rs2 = b; rs2_use = ub;
  endtask

  task automatic complete(input bit dn, input bit ld, input logic [4:0] r);
    done = dn; done_load = ld; done_rd = r;
  endtask

  // One clock: check every output against the model mid-cycle, then advance it.
  task automatic step();
    bit raw, waw, full, e_stall, issue, nerr, ndr;
    logic [31:0] nsb;
    int ncnt;
    @(negedge clk);
    raw     = (rs1_use && m_sb[rs1]) || (rs2_use && m_sb[rs2]);
    waw     = is_load && m_sb[rd];
    full    = (is_load || is_store) && (m_cnt == MAX);
    e_stall = m_drain ? 1'b1 : (valid && (raw || waw || full || (drain && m_cnt != 0)));
    last_stall = stall_o;
    n_checks += 5;
    if (stall_o !== e_stall) begin
      n_fail++; $display("FAIL stall: got %b expected %b at %0t", stall_o, e_stall, $time);
    end
    if (sb_o !== m_sb) begin
      n_fail++; $display("FAIL sb: got %h expected %h at %0t", sb_o, m_sb, $time);
    end
    if (outst_o !== CW'(m_cnt)) begin
      n_fail++; $display("FAIL outst: got %0d expected %0d at %0t", outst_o, m_cnt, $time);
    end
    if (drain_o !== m_drain) begin
      n_fail++; $display("FAIL drain: got %b expected %b at %0t", drain_o, m_drain, $time);
    end
    if (err_o !== m_err) begin
      n_fail++; $display("FAIL err: got %b expected %b at %0t", err_o, m_err, $time);
    end
    issue = valid && !e_stall;
    nsb  = m_sb;
    nerr = m_err;
    if (done && done_load) nsb[done_rd] = 1'b0;
    if (issue && is_load && rd != 0) begin
      if (done && done_load && done_rd == rd) nerr = 1;
      nsb[rd] = 1'b1;
    end
    nsb[0] = 1'b0;
    ncnt = m_cnt;
    if (done && m_cnt == 0) nerr = 1;
    else ncnt = m_cnt + ((issue && (is_load || is_store)) ? 1 : 0) - (done ? 1 : 0);
    ndr = m_drain ? (m_cnt != 0) : (valid && drain && m_cnt != 0);
    if (done && exp_q.size() > 0) void'(exp_q.pop_front());
    if (issue && (is_load || is_store)) exp_q.push_back({is_load, rd});
    @(posedge clk);
    #1;
    m_sb = nsb; m_cnt = ncnt; m_drain = ndr; m_err = nerr;
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    #12;
    rst = 0;
    model_reset();
    @(posedge clk); #1;
    check_val("reset_sb", sb_o, 0);
    check_val("reset_outst", outst_o, 0);
    check_val("reset_err", err_o, 0);
    check_val("reset_drain", drain_o, 0);
    check_val("reset_stall", stall_o, 0);
    step();
  endtask

  task automatic test_load_use();
    idle(); instr(1, 0, 0, 5'd5, 5'd0, 0, 5'd0, 0); step();
    check_val("lu_sb5_set", sb_o[5], 1);
    idle(); instr(0, 0, 0, 5'd6, 5'd1, 1, 5'd5, 1); step();
    check_val("lu_stalled", last_stall, 1);
    step();
    complete(1, 1, 5'd5); step();
    check_val("lu_stall_on_done", last_stall, 1);
    check_val("lu_sb5_clr", sb_o[5], 0);
    complete(0, 0, 5'd0); step();
    check_val("lu_issue", last_stall, 0);
    idle(); step();
  endtask

  task automatic test_load_x0();
    idle(); instr(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0); step();
    check_val("x0_sb", sb_o, 0);
    check_val("x0_outst", outst_o, 1);
    idle(); instr(0, 0, 0, 5'd2, 5'd0, 1, 5'd0, 1); step();
    check_val("x0_reader", last_stall, 0);
    idle(); complete(1, 1, 5'd0); step();
    idle(); step();
  endtask

  task automatic test_back_to_back();
    idle(); instr(0, 1, 0, 5'd0, 5'd1, 1, 5'd2, 1); step();
    step();
    check_val("b2b_outst2", outst_o, 2);
    complete(1, 0, 5'd0); step();
    check_val("b2b_third_stall", last_stall, 1);
    complete(0, 0, 5'd0); step();
    check_val("b2b_third_issue", last_stall, 0);
    check_val("b2b_outst_stays", outst_o, 2);
    idle();
  endtask

  task automatic test_fence();
    // Entered with two stores in flight.
    idle(); instr(0, 0, 1, 5'd0, 5'd0, 0, 5'd0, 0); step();
    check_val("fence_drain_on", drain_o, 1);
    complete(1, 0, 5'd0); step();
    step();
    check_val("fence_outst0", outst_o, 0);
    check_val("fence_still_drain", drain_o, 1);
    complete(0, 0, 5'd0); step();
    check_val("fence_hold_zero_cycle", last_stall, 1);
    step();
    check_val("fence_issue", last_stall, 0);
    check_val("fence_drain_off", drain_o, 0);
    idle(); step();
  endtask

  task automatic test_simul_set_clear();
    idle(); instr(1, 0, 0, 5'd3, 5'd0, 0, 5'd0, 0); step();
    instr(1, 0, 0, 5'd7, 5'd0, 0, 5'd0, 0); complete(1, 1, 5'd3); step();
    check_val("simul_sb", sb_o, 32'h80);
    idle(); complete(1, 1, 5'd7); step();
    idle(); step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int kind;
      idle();
      valid = ($urandom_range(0, 3) != 0);
      kind  = $urandom_range(0, 9);
      is_load  = (kind < 4);
      is_store = (kind >= 4 && kind < 7);
      drain    = (kind == 9);
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rs1_use = $urandom_range(0, 1);
      rs2_use = $urandom_range(0, 1);
      if (exp_q.size() > 0 && $urandom_range(0, 1) == 1)
        complete(1, exp_q[0][5], exp_q[0][4:0]);
      step();
    end
    idle();
    while (exp_q.size() > 0) begin
      complete(1, exp_q[0][5], exp_q[0][4:0]);
      step();
    end
    idle(); step(); step();
  endtask

  task automatic test_collision();
    idle(); instr(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0); step();
    instr(1, 0, 0, 5'd9, 5'd0, 0, 5'd0, 0); complete(1, 1, 5'd9); step();
    check_val("collide_err", err_o, 1);
    check_val("collide_set_wins", sb_o[9], 1);
    idle(); complete(1, 1, 5'd9); step();
    idle(); step();
    rst = 1; #2; rst = 0; model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_underflow_async_reset();
    idle(); complete(1, 0, 5'd0); step();
    check_val("uf_err", err_o, 1);
    check_val("uf_outst", outst_o, 0);
    idle(); step(); step();
    check_val("uf_sticky", err_o, 1);
    instr(1, 0, 0, 5'd9, 5'd0, 0, 5'd0, 0); step();
    idle();
    #2 rst = 1;
    #1;
    check_val("arst_err", err_o, 0);
    check_val("arst_sb", sb_o, 0);
    check_val("arst_outst", outst_o, 0);
    #1 rst = 0;
    model_reset();
    @(posedge clk); #1;
    step();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_load_x0();
    test_back_to_back();
    test_fence();
    test_simul_set_clear();
    test_random();
    test_collision();
    test_underflow_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, limit 200000 reached");
    $fatal(1);
  end

endmodule
